// File: rtl/snake_head_stepper.sv
// snake_head_stepper: paced head-position stepper for a grid snake game.
// Every TICK_DIV cycles in RUN the head moves one cell in the sampled
// direction and the new position is offered downstream with a valid/ready
// handshake. Only one step can be outstanding at a time.
// Optional build macro: SNAKE_WRAP_EN makes edge moves wrap to the opposite
// side instead of killing the snake.
module snake_head_stepper #(
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int X_W      = 6,
  parameter int Y_W      = 5,
  parameter int TICK_DIV = 5000000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [1:0]     dir,
  input  logic           step_ready,
  output logic           step_valid,
  output logic [X_W-1:0] head_x,
  output logic [Y_W-1:0] head_y,
  output logic           running,
  output logic           dead
);

  localparam int             CNT_W     = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [X_W-1:0] X_MAX     = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0] Y_MAX     = Y_W'(GRID_H - 1);
  localparam logic [X_W-1:0] X_MID     = X_W'(GRID_W / 2);
  localparam logic [Y_W-1:0] Y_MID     = Y_W'(GRID_H / 2);

  typedef enum logic [1:0] {IDLE, RUN, WAIT, DEAD} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [X_W-1:0]   x_nxt;
  logic [Y_W-1:0]   y_nxt;
  logic [X_W:0]     step_x_res;
  logic [Y_W:0]     step_y_res;
  logic             hit;

  // Next column for direction d: returns {collision, new_x}. Moves along Y
  // leave the column alone.
  function automatic logic [X_W:0] step_x(input logic [X_W-1:0] x, input logic [1:0] d);
    logic [X_W:0] r;
    r = {1'b0, x};
    if (d == 2'b00) begin
      if (x == X_MAX) begin
`ifdef SNAKE_WRAP_EN
        r = {1'b0, {X_W{1'b0}}};
`else
        r = {1'b1, x};
`endif
      end else begin
        r = {1'b0, x + X_W'(1)};
      end
    end else if (d == 2'b01) begin
      if (x == '0) begin
`ifdef SNAKE_WRAP_EN
        r = {1'b0, X_MAX};
`else
        r = {1'b1, x};
`endif
      end else begin
        r = {1'b0, x - X_W'(1)};
      end
    end
    return r;
  endfunction

  // Next row for direction d: returns {collision, new_y}.
  function automatic logic [Y_W:0] step_y(input logic [Y_W-1:0] y, input logic [1:0] d);
    logic [Y_W:0] r;
    r = {1'b0, y};
    if (d == 2'b10) begin
      if (y == '0) begin
`ifdef SNAKE_WRAP_EN
        r = {1'b0, Y_MAX};
`else
        r = {1'b1, y};
`endif
      end else begin
        r = {1'b0, y - Y_W'(1)};
      end
    end else if (d == 2'b11) begin
      if (y == Y_MAX) begin
`ifdef SNAKE_WRAP_EN
        r = {1'b0, {Y_W{1'b0}}};
`else
        r = {1'b1, y};
`endif
      end else begin
        r = {1'b0, y + Y_W'(1)};
      end
    end
    return r;
  endfunction

  // Candidate move for the current head and direction.
  always_comb begin
    step_x_res = step_x(head_x, dir);
    step_y_res = step_y(head_y, dir);
    hit        = step_x_res[X_W] | step_y_res[Y_W];
  end

  // Next-state logic: pacing counter, step issue, handshake and game over.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    x_nxt     = head_x;
    y_nxt     = head_y;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        if (cnt == TICK_LAST) begin
          cnt_nxt = '0;
          if (hit) begin
            state_nxt = DEAD;
          end else begin
            state_nxt = WAIT;
            x_nxt     = step_x_res[X_W-1:0];
            y_nxt     = step_y_res[Y_W-1:0];
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      WAIT: begin
        cnt_nxt = '0;
        if (step_ready) begin
          state_nxt = RUN;
        end
      end
      DEAD: begin
        if (start) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
          x_nxt     = X_MID;
          y_nxt     = Y_MID;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counter and head registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      head_x <= X_MID;
      head_y <= Y_MID;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      head_x <= x_nxt;
      head_y <= y_nxt;
    end
  end

  assign step_valid = (state == WAIT);
  assign running    = (state == RUN) || (state == WAIT);
  assign dead       = (state == DEAD);

endmodule

// File: tb/tb_snake_head_stepper.sv
// tb_snake_head_stepper: directed bench for snake_head_stepper with
// GRID 40x30 and TICK_DIV=4. Wall behaviour follows SNAKE_WRAP_EN.
module tb_snake_head_stepper;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] dir = 2'b00;
  logic       step_ready = 1'b0;
  logic       step_valid;
  logic [5:0] head_x;
  logic [4:0] head_y;
  logic       running;
  logic       dead;

  int checks = 0;
  int errors = 0;
  int n;

  snake_head_stepper #(
    .GRID_W(40), .GRID_H(30), .X_W(6), .Y_W(5), .TICK_DIV(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dir(dir),
    .step_ready(step_ready), .step_valid(step_valid),
    .head_x(head_x), .head_y(head_y), .running(running), .dead(dead)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until step_valid is seen, bounded; returns cycles taken.
  task automatic wait_step(output int cyc);
    cyc = 0;
    while (!step_valid && cyc < 12) begin
      tick();
      cyc++;
    end
  endtask

  // One full move in direction d, including the handshake cycle.
  task automatic move(input logic [1:0] d);
    int c;
    dir = d;
    step_ready = 1'b1;
    wait_step(c);
    if (!step_valid) check("move_timeout", step_valid, 1);
    tick();
  endtask

  initial begin
    // Reset and idle
    tick(); tick();
    rst_n = 1'b1;
    check("rst_x", head_x, 20);
    check("rst_y", head_y, 15);
    check("rst_valid", step_valid, 0);
    check("rst_running", running, 0);
    check("rst_dead", dead, 0);
    tick(); tick(); tick();
    check("idle_running", running, 0);
    check("idle_valid", step_valid, 0);

    // Start, dir right, always ready: step every 5 cycles
    start = 1'b1; dir = 2'b00; step_ready = 1'b1;
    tick();
    start = 1'b0;
    check("start_running", running, 1);
    check("start_valid", step_valid, 0);
    wait_step(n);
    check("lat1", n, 4);
    check("step1_x", head_x, 21);
    check("step1_y", head_y, 15);
    tick();
    check("hs1_valid", step_valid, 0);
    wait_step(n);
    check("lat2", n, 4);
    check("step2_x", head_x, 22);

    // Backpressure: valid and head held, no extra step
    step_ready = 1'b0;
    repeat (20) tick();
    check("bp_valid", step_valid, 1);
    check("bp_x", head_x, 22);
    check("bp_y", head_y, 15);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("wait_start_valid", step_valid, 1);
    check("wait_start_x", head_x, 22);
    check("wait_start_run", running, 1);
    step_ready = 1'b1;
    tick();
    check("hs2_valid", step_valid, 0);
    wait_step(n);
    check("lat3", n, 4);
    check("step3_x", head_x, 23);

    // Direction changed exactly in the terminal-tick cycle
    tick();
    tick(); tick(); tick();
    check("pre_term_valid", step_valid, 0);
    dir = 2'b10;
    tick();
    check("term_valid", step_valid, 1);
    check("term_x", head_x, 23);
    check("term_y", head_y, 14);

    // Reset during WAIT, with start and ready asserted too
    step_ready = 1'b0;
    tick();
    check("wait_hold", step_valid, 1);
    rst_n = 1'b0; start = 1'b1; step_ready = 1'b1;
    tick();
    check("wrst_valid", step_valid, 0);
    check("wrst_x", head_x, 20);
    check("wrst_y", head_y, 15);
    check("wrst_running", running, 0);
    check("wrst_dead", dead, 0);
    rst_n = 1'b1; start = 1'b0;
    tick();
    check("wrst_idle", running, 0);

    // New game
    start = 1'b1; dir = 2'b00;
    tick();
    start = 1'b0;
`ifdef SNAKE_WRAP_EN
    repeat (15) move(2'b01);
    repeat (14) move(2'b11);
    check("pre_wrap_x", head_x, 5);
    check("pre_wrap_y", head_y, 29);
    dir = 2'b11;
    wait_step(n);
    check("wrapy_lat", n, 4);
    check("wrapy_valid", step_valid, 1);
    check("wrapy_x", head_x, 5);
    check("wrapy_y", head_y, 0);
    check("wrapy_dead", dead, 0);
    tick();
    repeat (3) move(2'b11);
    repeat (34) move(2'b00);
    check("pre_wrapx_x", head_x, 39);
    check("pre_wrapx_y", head_y, 3);
    dir = 2'b00;
    wait_step(n);
    check("wrapx_valid", step_valid, 1);
    check("wrapx_x", head_x, 0);
    check("wrapx_y", head_y, 3);
    check("wrapx_dead", dead, 0);
`else
    repeat (8) move(2'b10);
    repeat (20) move(2'b01);
    check("pre_wall_x", head_x, 0);
    check("pre_wall_y", head_y, 7);
    dir = 2'b01;
    tick(); tick(); tick();
    check("pre_dead", dead, 0);
    tick();
    check("dead", dead, 1);
    check("dead_valid", step_valid, 0);
    check("dead_x", head_x, 0);
    check("dead_y", head_y, 7);
    check("dead_running", running, 0);
    repeat (5) tick();
    check("dead_hold", dead, 1);
    check("dead_hold_x", head_x, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_x", head_x, 20);
    check("restart_y", head_y, 15);
    check("restart_dead", dead, 0);
    check("restart_running", running, 1);
    wait_step(n);
    check("restart_lat", n, 4);
    check("restart_step_x", head_x, 19);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
